// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, reset PC, fetch FSM states and
// the opcode field position used by both fetch and the control unit.
package core_pkg;

  localparam int PC_WIDTH    = 64;
  localparam int INSTR_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

  // Opcode field of the A64 instruction word, decoded by the control unit.
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 21;
  localparam int OPC_WIDTH = OPC_MSB - OPC_LSB + 1;

  // REQ: request outstanding at pc; IDLE: hold buffer full, no request;
  // DROP: waiting out the ack of a request squashed by a branch.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    IDLE = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a 1-entry hold buffer. Absorbs one fetched
// instruction while decode stalls; a flush empties both entries.
module if_id_reg #(
  parameter int PC_WIDTH    = core_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = core_pkg::INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_stall,
  input  logic                   i_in_valid,
  input  logic [PC_WIDTH-1:0]    i_in_pc,
  input  logic [INSTR_WIDTH-1:0] i_in_instr,
  output logic                   o_valid,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_hold_next
);

  logic                   r_valid;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_hold_valid;
  logic [PC_WIDTH-1:0]    r_hold_pc;
  logic [INSTR_WIDTH-1:0] r_hold_instr;
  logic                   w_hold_next;
  logic                   w_to_hold;

  // Occupancy of the hold buffer after this edge; the fetch FSM uses it to
  // decide whether another request may be issued.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_hold_next = 1'b0;
    w_to_hold   = 1'b0;
    if (!i_flush) begin
      if (i_stall) begin
        w_to_hold   = i_in_valid && r_valid;
        w_hold_next = r_hold_valid || w_to_hold;
      end else begin
        w_to_hold   = i_in_valid && r_hold_valid;
        w_hold_next = w_to_hold;
      end
    end
  end

  // IF/ID register: hold entry drains first, then new data, else a bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst || i_flush) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_hold_valid <= 1'b0;
    end else begin
      r_hold_valid <= w_hold_next;
      if (!i_stall) begin
        if (r_hold_valid) begin
          r_valid <= 1'b1;
          r_pc    <= r_hold_pc;
          r_instr <= r_hold_instr;
        end else if (i_in_valid) begin
          r_valid <= 1'b1;
          r_pc    <= i_in_pc;
          r_instr <= i_in_instr;
        end else begin
          r_valid <= 1'b0;
          r_pc    <= '0;
          r_instr <= '0;
        end
      end else if (!r_valid && i_in_valid) begin
        // An empty slot accepts data even while decode stalls.
        r_valid <= 1'b1;
        r_pc    <= i_in_pc;
        r_instr <= i_in_instr;
      end
    end
  end

  // Hold payload capture.
  always_ff @(posedge clk) begin
    // NOTE: the payload is qualified by r_hold_valid, so it carries no reset.
    if (w_to_hold) begin
      r_hold_pc    <= i_in_pc;
      r_hold_instr <= i_in_instr;
    end
  end

  assign o_valid     = r_valid;
  assign o_pc        = r_pc;
  assign o_instr     = r_instr;
  assign o_hold_next = w_hold_next;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding req/ack
// handshake with instruction memory, squashes in-flight fetches on branch
// redirects and feeds the IF/ID register.
module fetch_stage
  import core_pkg::*;
#(
  parameter int                   PC_WIDTH    = core_pkg::PC_WIDTH,
  parameter int                   INSTR_WIDTH = core_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(core_pkg::RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   if_id_valid,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [OPC_WIDTH-1:0]   if_id_opcode
);

  fetch_state_e          r_state;
  fetch_state_e          w_state_next;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_next;
  logic [PC_WIDTH-1:0]   r_addr;
  logic                  w_accept;
  logic                  w_hold_next;

  // Only an ack to a live request in REQ delivers an instruction; acks in
  // DROP, stale acks in IDLE and acks coinciding with a branch are dropped.
  assign w_accept = (r_state == REQ) && imem_ack && !branch_taken;

  // Next PC and next FSM state.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (branch_taken) begin
      w_pc_next = branch_target;
    end else if (w_accept) begin
      w_pc_next = r_pc + PC_WIDTH'(4);
    end
    case (r_state)
      REQ: begin
        if (branch_taken) begin
          w_state_next = imem_ack ? REQ : DROP;
        end else if (imem_ack) begin
          w_state_next = w_hold_next ? IDLE : REQ;
        end
      end
      IDLE:    w_state_next = w_hold_next ? IDLE : REQ;
      DROP:    if (imem_ack) w_state_next = REQ;
      default: w_state_next = REQ;
    endcase
  end

  // State, PC and request address registers. The address freezes while a
  // squashed request is still outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_state_next != DROP) begin
        r_addr <= w_pc_next;
      end
    end
  end

  assign imem_req  = (r_state != IDLE);
  assign imem_addr = r_addr;

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (branch_taken),
    .i_stall     (stall),
    .i_in_valid  (w_accept),
    .i_in_pc     (r_pc),
    .i_in_instr  (imem_rdata),
    .o_valid     (if_id_valid),
    .o_pc        (if_id_pc),
    .o_instr     (if_id_instr),
    .o_hold_next (w_hold_next)
  );

  assign if_id_opcode = if_id_instr[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with a scoreboard of
// instructions expected to reach IF/ID, plus direct handshake checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [10:0] if_id_opcode;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_opcode  (if_id_opcode)
  );

  // Memory contents: address 0 holds ADD X0,X1,X2 (0x8B020020).
  function automatic logic [31:0] mk(input logic [63:0] a);
    return 32'h8B020020 + a[31:0];
  endfunction

  // One clock: drive inputs, push the expected IF/ID entry if this ack should
  // survive, then sample 1 time unit after the edge and score IF/ID.
  task automatic cyc(input logic a_rst, input logic a_ack, input logic a_stall,
                     input logic a_br, input logic [63:0] a_tgt,
                     input logic a_push, input logic [63:0] a_pc);
    exp_t        e;
    logic [31:0] ei;
    rst           = a_rst;
    imem_ack      = a_ack;
    imem_rdata    = mk(imem_addr);
    stall         = a_stall;
    branch_taken  = a_br;
    branch_target = a_tgt;
    if (a_push) begin
      e.pc    = a_pc;
      e.instr = mk(a_pc);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    rst          = 1'b0;
    if (if_id_valid && (!a_stall || !prev_valid)) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc %h instr %h, required no new entry", if_id_pc, if_id_instr);
      end else begin
        e  = sb_q.pop_front();
        ei = e.instr;
        if (if_id_pc !== e.pc || if_id_instr !== e.instr || if_id_opcode !== ei[31:21]) begin
          n_err++;
          $display("FAIL sb_entry: got pc %h instr %h opc %h, required pc %h instr %h opc %h",
                   if_id_pc, if_id_instr, if_id_opcode, e.pc, e.instr, ei[31:21]);
        end
      end
    end else if (!if_id_valid) begin
      n_vec++;
      if (if_id_instr !== 32'h0 || if_id_opcode !== 11'h0) begin
        n_err++;
        $display("FAIL invalid_nop: got instr %h opc %h, required 0 and 0", if_id_instr, if_id_opcode);
      end
    end
    prev_valid = if_id_valid;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 64'h0, 0, 64'h0);
    cyc(1, 1, 0, 0, 64'h0, 0, 64'h0);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL reset_req: got req %b addr %h, required 1 and 0", imem_req, imem_addr);
    end
    n_vec++;
    if (if_id_valid !== 1'b0 || if_id_pc !== 64'h0 || if_id_instr !== 32'h0 || if_id_opcode !== 11'h0) begin
      n_err++;
      $display("FAIL reset_ifid: got v %b pc %h instr %h opc %h, required all 0",
               if_id_valid, if_id_pc, if_id_instr, if_id_opcode);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 64'(4 * i)) begin
        n_err++;
        $display("FAIL stream_addr%0d: got req %b addr %h, required 1 and %h", i, imem_req, imem_addr, 64'(4 * i));
      end
      cyc(0, 1, 0, 0, 64'h0, 1, 64'(4 * i));
      if (i == 0) begin
        n_vec++;
        if (if_id_opcode !== 11'h458) begin
          n_err++;
          $display("FAIL stream_opcode: got %h, required 458", if_id_opcode);
        end
      end
    end
    cyc(0, 0, 0, 0, 64'h0, 0, 64'h0);
    n_vec++;
    if (imem_addr !== 64'h10 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end: got addr %h v %b, required 10 and 0", imem_addr, if_id_valid);
    end
  endtask

  task automatic test_stall();
    cyc(0, 1, 1, 0, 64'h0, 1, 64'h10);
    cyc(0, 1, 1, 0, 64'h0, 1, 64'h14);
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL stall_idle: got req %b, required 0", imem_req);
    end
    cyc(0, 0, 1, 0, 64'h0, 0, 64'h0);
    n_vec++;
    if (imem_req !== 1'b0 || if_id_pc !== 64'h10 || if_id_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_hold: got req %b pc %h v %b, required 0 10 1", imem_req, if_id_pc, if_id_valid);
    end
    cyc(0, 0, 0, 0, 64'h0, 0, 64'h0);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h18) begin
      n_err++;
      $display("FAIL stall_resume: got req %b addr %h, required 1 and 18", imem_req, imem_addr);
    end
    cyc(0, 1, 0, 0, 64'h0, 1, 64'h18);
  endtask

  task automatic test_branch_drop();
    cyc(0, 1, 0, 0, 64'h0, 1, 64'h1C);
    cyc(0, 0, 0, 1, 64'h100, 0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h20 || if_id_valid !== 1'b0) begin
        n_err++;
        $display("FAIL drop_hold%0d: got req %b addr %h v %b, required 1 20 0", i, imem_req, imem_addr, if_id_valid);
      end
      if (i < 2) cyc(0, 0, 0, 0, 64'h0, 0, 64'h0);
    end
    cyc(0, 1, 0, 0, 64'h0, 0, 64'h0);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h100 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_redirect: got req %b addr %h v %b, required 1 100 0", imem_req, imem_addr, if_id_valid);
    end
    cyc(0, 1, 0, 0, 64'h0, 1, 64'h100);
  endtask

  task automatic test_branch_flush();
    cyc(0, 1, 1, 0, 64'h0, 0, 64'h0);
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: got req %b, required 0", imem_req);
    end
    cyc(0, 1, 1, 1, 64'h200, 0, 64'h0);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h200 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_target: got req %b addr %h v %b, required 1 200 0", imem_req, imem_addr, if_id_valid);
    end
    cyc(0, 1, 1, 0, 64'h0, 1, 64'h200);
    n_vec++;
    if (imem_addr !== 64'h204) begin
      n_err++;
      $display("FAIL flush_next: got addr %h, required 204", imem_addr);
    end
  endtask

  task automatic test_wrap();
    cyc(0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0);
    n_vec++;
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_target: got addr %h, required fffffffffffffffc", imem_addr);
    end
    cyc(0, 1, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL wrap_addr: got req %b addr %h, required 1 and 0", imem_req, imem_addr);
    end
    cyc(0, 1, 0, 0, 64'h0, 1, 64'h0);
  endtask

  task automatic test_reset_in_drop();
    cyc(0, 0, 0, 1, 64'h300, 0, 64'h0);
    n_vec++;
    if (imem_addr !== 64'h4 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rdrop_enter: got req %b addr %h, required 1 and 4", imem_req, imem_addr);
    end
    cyc(1, 1, 0, 0, 64'h0, 0, 64'h0);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0 || if_id_valid !== 1'b0 || if_id_pc !== 64'h0) begin
      n_err++;
      $display("FAIL rdrop_reset: got req %b addr %h v %b pc %h, required 1 0 0 0",
               imem_req, imem_addr, if_id_valid, if_id_pc);
    end
    cyc(0, 1, 0, 0, 64'h0, 1, 64'h0);
    n_vec++;
    if (imem_addr !== 64'h4) begin
      n_err++;
      $display("FAIL rdrop_resume: got addr %h, required 4", imem_addr);
    end
    cyc(0, 0, 0, 0, 64'h0, 0, 64'h0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_drop();
    test_branch_flush();
    test_wrap();
    test_reset_in_drop();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending entries, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
